// File: rtl/alu_seq.sv
// Multi-cycle integer ALU: one-cycle add/sub/logic ops, WIDTH-cycle shift-add multiply.
// Define ALU_SEQ_SIGNED_MUL_EN to enable signed multiply (MULS) on op 3.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op_select,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               overflow,
  output logic               cout,
  output logic               busy
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MULU = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
`ifdef ALU_SEQ_SIGNED_MUL_EN
  localparam logic [2:0] OP_MULS = 3'd3;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  state_t r_state, w_state_next;

  logic [WIDTH-1:0]   r_mplier, r_cnt;
  logic [2*WIDTH-1:0] r_mcand, r_acc, r_result;
  logic               r_overflow, r_cout;

  logic               w_accept, w_is_mul, w_mul_last;
  logic [WIDTH-1:0]   w_b_eff, w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_res, w_acc_next, w_prod;
  logic               w_ovf, w_cout, w_mul_ovf;

  // NOTE: in_ready is combinational so a result handshake and a new acceptance can share an edge.
  assign in_ready   = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_mul_last = (r_cnt == '0);
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef ALU_SEQ_SIGNED_MUL_EN
  logic r_neg, r_signed, w_is_muls;
  assign w_is_muls = (op_select == OP_MULS);
  assign w_is_mul  = (op_select == OP_MULU) || w_is_muls;
  assign w_mag_a   = (w_is_muls && a[WIDTH-1]) ? -a : a;
  assign w_mag_b   = (w_is_muls && b[WIDTH-1]) ? -b : b;
  assign w_prod    = r_neg ? -w_acc_next : w_acc_next;
  // Signed product fits in WIDTH bits only if the top WIDTH+1 bits are sign copies.
  assign w_mul_ovf = r_signed ? ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]))
                              : (|w_prod[2*WIDTH-1:WIDTH]);
`else
  assign w_is_mul  = (op_select == OP_MULU);
  assign w_mag_a   = a;
  assign w_mag_b   = b;
  assign w_prod    = w_acc_next;
  assign w_mul_ovf = |w_prod[2*WIDTH-1:WIDTH];
`endif

  // Single-cycle ops; SUB is a + ~b + cin so cin=1 yields a-b.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_b_eff = (op_select == OP_SUB) ? ~b : b;
    w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, cin};
    w_res   = '0;
    w_ovf   = 1'b0;
    w_cout  = 1'b0;
    case (op_select)
      OP_ADD, OP_SUB: begin
        w_res  = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
        w_cout = w_sum[WIDTH];
        w_ovf  = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_res = {{WIDTH{1'b0}}, a & b};
      OP_OR:   w_res = {{WIDTH{1'b0}}, a | b};
      OP_XOR:  w_res = {{WIDTH{1'b0}}, a ^ b};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = w_is_mul ? S_MUL : S_DONE;
      S_MUL:   if (w_mul_last) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = w_accept ? (w_is_mul ? S_MUL : S_DONE) : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mplier   <= '0;
      r_cnt      <= '0;
      r_mcand    <= '0;
      r_acc      <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_cout     <= 1'b0;
`ifdef ALU_SEQ_SIGNED_MUL_EN
      r_neg      <= 1'b0;
      r_signed   <= 1'b0;
`endif
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
        r_mplier <= w_mag_b;
        r_cnt    <= WIDTH'(WIDTH - 1);
`ifdef ALU_SEQ_SIGNED_MUL_EN
        r_neg    <= w_is_muls && (a[WIDTH-1] ^ b[WIDTH-1]);
        r_signed <= w_is_muls;
`endif
      end else begin
        r_result   <= w_res;
        r_overflow <= w_ovf;
        r_cout     <= w_cout;
      end
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - WIDTH'(1);
      if (w_mul_last) begin
        r_result   <= w_prod;
        r_overflow <= w_mul_ovf;
        r_cout     <= 1'b0;
      end
    end
  end

  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_MUL);
  assign result    = r_result;
  assign overflow  = r_overflow;
  assign cout      = r_cout;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); expectations follow ALU_SEQ_SIGNED_MUL_EN.
module tb_alu_seq;

  logic        clk, reset, in_valid, in_ready, cin, out_valid, out_ready;
  logic        overflow, cout, busy;
  logic [31:0] a, b;
  logic [2:0]  op_select;
  logic [63:0] result;
  int          n_checks = 0;
  int          n_errors = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_select(op_select), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .cout(cout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the acceptance edge.
  task automatic send(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                      input logic vc);
    int t = 0;
    op_select = op; a = va; b = vb; cin = vc; in_valid = 1'b1;
    #1;
    while (!in_ready && t < 50) begin
      @(negedge clk); #1; t++;
    end
    check("send_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = ~va; b = ~vb; op_select = 3'd7; cin = ~vc;
  endtask

  task automatic expect_out(input string tag, input logic [63:0] r, input logic co,
                            input logic ov);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_result"}, result, r);
    check({tag, "_cout"}, cout, co);
    check({tag, "_ovf"}, overflow, ov);
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk); n++;
    end
  endtask

  initial begin
    int n_busy, lat, bad;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op_select = '0; cin = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cout", cout, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b1;
    out_ready = 1'b1;

    // Back-to-back single-cycle ops, one per cycle.
    send(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    expect_out("add", 64'h0, 1'b1, 1'b0);
    send(3'd1, 32'h8000_0000, 32'h0000_0001, 1'b1);
    expect_out("sub", 64'h0000_0000_7FFF_FFFF, 1'b1, 1'b1);
    send(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    expect_out("illegal", 64'h0, 1'b0, 1'b0);
    send(3'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b1);
    expect_out("and", 64'h0000_0000_F0F0_0000, 1'b0, 1'b0);
    send(3'd5, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0);
    expect_out("or", 64'h0000_0000_FFFF_F0F0, 1'b0, 1'b0);
    @(negedge clk);
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);

    // Unsigned multiply: busy for 32 cycles, result in cycle 33.
    send(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    n_busy = 0;
    for (int i = 0; i < 32; i++) begin
      if (busy && !out_valid) n_busy++;
      @(negedge clk);
    end
    check("mulu_busy_cycles", n_busy, 32);
    check("mulu_busy_end", busy, 0);
    expect_out("mulu", 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1);
    send(3'd2, 32'd7, 32'd6, 1'b1);
    wait_done(lat);
    check("mulu_small_latency", lat, 33);
    expect_out("mulu_small", 64'd42, 1'b0, 1'b0);

    // Op 3: signed multiply when enabled, illegal otherwise.
    send(3'd3, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    wait_done(lat);
`ifdef ALU_SEQ_SIGNED_MUL_EN
    check("muls_latency", lat, 33);
    expect_out("muls_neg", 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b0);
`else
    check("muls_latency", lat, 1);
    expect_out("muls_neg", 64'h0, 1'b0, 1'b0);
`endif
    send(3'd3, 32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_done(lat);
`ifdef ALU_SEQ_SIGNED_MUL_EN
    expect_out("muls_min", 64'h4000_0000_0000_0000, 1'b0, 1'b1);
`else
    expect_out("muls_min", 64'h0, 1'b0, 1'b0);
`endif

    // Backpressure: XOR result held for 5 cycles while a competing bundle is offered.
    @(negedge clk);
    out_ready = 1'b0;
    send(3'd6, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0);
    expect_out("xor", 64'h0000_0000_0F0F_F0F0, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; op_select = 3'd5; in_valid = 1'b1;
      #1;
      if (!out_valid || in_ready || result !== 64'h0000_0000_0F0F_F0F0) bad++;
      @(negedge clk);
    end
    check("bp_hold", bad, 0);
    out_ready = 1'b1;
    a = 32'h7FFF_FFFF; b = 32'h0000_0001; op_select = 3'd0; cin = 1'b0; in_valid = 1'b1;
    #1;
    check("bp_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    expect_out("bp_add", 64'h0000_0000_8000_0000, 1'b0, 1'b1);

    // Reset at multiply iteration 10 discards the operation.
    send(3'd2, 32'h1234_5678, 32'h0000_0009, 1'b0);
    repeat (10) @(negedge clk);
    check("mid_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    send(3'd0, 32'd2, 32'd3, 1'b0);
    expect_out("post_rst_add", 64'd5, 1'b0, 1'b0);
    @(negedge clk);
    check("post_rst_drain", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle integer ALU that replaces the fixed-width single-shot ALU. Operands, op code and carry-in are accepted over a valid/ready handshake. Add, subtract and logic ops complete in one cycle; multiply uses an iterative shift-add datapath taking WIDTH cycles. The result is held under output backpressure. The block sits between the operand-issue logic and the writeback stage.

## Interface
- WIDTH, 32: operand width in bits, ≥ 4. The result is 2*WIDTH bits.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept a bundle this cycle.
- a, b  input  WIDTH  operands.
- op_select  input  3  0 ADD, 1 SUB, 2 MULU, 3 MULS, 4 AND, 5 OR, 6 XOR, 7 illegal.
- cin  input  1  carry-in; used by ADD and SUB only.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  2*WIDTH  result.
- overflow  output  1  overflow flag.
- cout  output  1  carry-out.
- busy  output  1  high while in the MUL state.

## Operation
- FSM states: IDLE, MUL, DONE. Reset state is IDLE.
- Reset values: out_valid=0, result=0, overflow=0, cout=0, busy=0. in_ready=1, since the FSM is in IDLE.
- Acceptance occurs on a rising edge with in_valid && in_ready. a, b, op_select and cin are captured at that edge; input changes afterwards have no effect.
- ADD: low = a + b + cin.
- SUB: low = a + ~b + cin. With cin=1 this gives a−b.
- For ADD and SUB:
  - result = {WIDTH zeros, low}.
  - cout = carry out of bit WIDTH-1.
  - overflow = two's-complement signed overflow.
  - State goes directly to DONE.
- AND/OR/XOR: result = zero-extended bitwise result; cout=0; overflow=0; state goes to DONE.
- Illegal op (7): result=0, cout=0, overflow=0; state goes to DONE. No error signal.
- MULU: unsigned 2*WIDTH-bit product; goes to MUL.
  - One multiplier bit is processed per cycle, LSB first, with a WIDTH-bit iteration counter.
  - On counter exhaustion, state goes to DONE.
  - cout=0; overflow=1 iff product[2W-1:W] ≠ 0.
- MULS (only when the macro is defined): signed product computed as follows:
  - Take operand magnitudes and run the unsigned iteration.
  - Negate the product if the operand signs differ.
  - overflow=1 iff product[2W-1:W-1] is not all-equal.
  - cout=0.
- DONE: out_valid=1 and result/flags held stable until out_valid && out_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Simultaneous result handshake and new acceptance in DONE: the new op is captured, and the next state is DONE or MUL per the new op.
- Handshake in DONE with no new acceptance: state goes to IDLE and out_valid drops.
- Reset asserted mid-operation: immediately returns to IDLE with all reset values; any in-flight op is discarded.

## Timing
- Acceptance edge N.
- ADD/SUB/logic/illegal: out_valid high after edge N+1.
- MULU/MULS: busy high after edges N+1 … N+WIDTH; out_valid high after edge N+WIDTH+1.
  - Latency is fixed; there is no early termination on zero operands.
- Back-to-back single-cycle ops with out_ready tied high: one op per cycle.
- Outputs are registered. in_ready is combinational from state and out_ready only.
- Reset deassertion is synchronised externally; the first acceptance can occur on the first rising edge after release.

## Configuration
- ALU_SEQ_SIGNED_MUL_EN:
  - Defined: op 3 performs MULS as specified, adding the magnitude/negation logic.
  - Undefined: op 3 is treated as illegal (result 0, flags 0, one-cycle latency) and the magnitude/negation logic is absent.

## Test plan
- ADD, WIDTH=32, a=0xFFFFFFFF, b=0x00000001, cin=0 → result=0x0000000000000000, cout=1, overflow=0; out_valid one cycle after acceptance.
- SUB, a=0x80000000, b=0x00000001, cin=1 → result=0x000000007FFFFFFF, cout=1, overflow=1.
- MULU, a=b=0xFFFFFFFF → busy for 32 cycles, then out_valid with result=0xFFFFFFFE00000001, overflow=1, cout=0 at cycle 33.
- MULS, a=0xFFFFFFFE (−2), b=0x00000003:
  - Macro defined → result=0xFFFFFFFFFFFFFFFA, overflow=0.
  - Macro undefined → result=0 after one cycle.
- Backpressure: complete an XOR (a=0xF0F0F0F0, b=0xFFFF0000 → 0x000000000F0FF0F0) with out_ready=0 for 5 cycles. result stays stable and in_ready=0. Raise out_ready with a new in_valid ADD → both handshakes occur on the same edge, and out_valid stays high with the ADD result next cycle.
- Reset mid-MUL: assert reset at MUL iteration 10 → out_valid=0, busy=0, result=0 immediately. After release, in_ready=1 and a fresh ADD 2+3 returns 5.
